ahb_mst_driver: RTL and testbench

AHB master stage that sits directly upstream of the AHB slave responder on the test bus. It accepts one burst command at a time and requests the bus through `hbusreq`/`hgrant`. It then drives the pipelined address and data phases (`haddr`/`htrans`/`hwrite`/`hsize`/`hburst`/`hwdata`) and returns read data and a completion status to the local side. It honours `hready` wait states and two-cycle ERROR responses.

---
 rtl/ahb_pkg.sv | 43 ++++
 rtl/ahb_mst_driver.sv | 266 ++++++++++++++++++++++++++
 tb/tb_ahb_mst_driver.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB encodings for the test-bus master: transfer types, burst types,
// response codes and the master state enum. Also provides the mapping from a
// beats-minus-one length to the AHB burst encoding.
// ----------------------------------------------------------------------------
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_LAST,
    ST_ERR
  } mst_state_e;

  // Fixed-length INCR bursts only exist for 4/8/16 beats; every other
  // multi-beat length goes out as undefined-length INCR.
  function automatic logic [2:0] burst_from_len(input logic [3:0] len);
    case (len)
      4'd0:    return HBURST_SINGLE;
      4'd3:    return HBURST_INCR4;
      4'd7:    return HBURST_INCR8;
      4'd15:   return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/ahb_mst_driver.sv
// ----------------------------------------------------------------------------
// ahb_mst_driver
// AHB master stage: takes one burst command at a time from the local side,
// requests the bus, drives pipelined address/data phases and returns read
// data plus a completion status.
//
// Ports
//   hclk, hreset                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_addr/write/size/len      start address, direction, beat size, beats-1
//   wdata_valid/wdata/wdata_ready  write beat stream
//   rdata_valid/rdata/rdata_last   read beat stream (no backpressure)
//   done/done_err                completion pulse and error qualifier
//   haddr..hwdata, hbusreq, hlock  registered AHB master outputs
//   hrdata, hready, hresp, hgrant  AHB slave/arbiter inputs (hmaster unused)
// ----------------------------------------------------------------------------
module ahb_mst_driver
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_size,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_last,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  output logic              hbusreq,
  output logic              hlock,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic              hgrant,
  input  logic [3:0]        hmaster
);

  mst_state_e        state_q, state_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;       // write beat staged for the issued address phase
  logic              hbusreq_q, hbusreq_d;
  logic [3:0]        remain_q, remain_d;   // beats still to complete after the current one
  logic              dph_q, dph_d;         // a data phase of an issued beat is in flight
  logic              dph_last_q, dph_last_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdata_last_q, rdata_last_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              wdata_ready_c;
  logic              launch, launch_seq;

  logic err_seen;
  // First cycle of a two-cycle ERROR response on the in-flight data phase.
  assign err_seen = dph_q && !hready && (hresp == HRESP_ERROR);

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    htrans_d      = htrans_q;
    haddr_d       = haddr_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;
    wbuf_d        = wbuf_q;
    hbusreq_d     = hbusreq_q;
    remain_d      = remain_q;
    dph_d         = dph_q;
    dph_last_d    = dph_last_q;
    rdata_valid_d = 1'b0;
    rdata_d       = rdata_q;
    rdata_last_d  = 1'b0;
    done_d        = 1'b0;
    done_err_d    = 1'b0;
    wdata_ready_c = 1'b0;
    launch        = 1'b0;
    launch_seq    = 1'b0;

    // Retire the in-flight data phase; reads hand back their beat.
    if (dph_q && hready) begin
      dph_d = 1'b0;
      if (!hwrite_q && hresp == HRESP_OKAY) begin
        rdata_valid_d = 1'b1;
        rdata_d       = hrdata;
        rdata_last_d  = dph_last_q;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_REQ;
          hbusreq_d = 1'b1;
          haddr_d   = cmd_addr;
          hwrite_d  = cmd_write;
          hsize_d   = cmd_size;
          hburst_d  = burst_from_len(cmd_len);
          remain_d  = cmd_len;
        end
      end
      ST_REQ: begin
        if (err_seen) begin
          state_d   = ST_ERR;
          htrans_d  = HTRANS_IDLE;
          hbusreq_d = 1'b0;
        end else if (hgrant && hready) begin
          state_d = ST_ADDR;
          launch  = 1'b1;
        end
      end
      ST_ADDR: begin
        if (err_seen) begin
          state_d   = ST_ERR;
          htrans_d  = HTRANS_IDLE;
          hbusreq_d = 1'b0;
        end else if (hready) begin
          if (htrans_q[1]) begin
            // NONSEQ/SEQ accepted: its data phase starts next cycle.
            dph_d      = 1'b1;
            dph_last_d = (remain_q == 4'd0);
            if (hwrite_q) hwdata_d = wbuf_q;
            if (remain_q == 4'd0) begin
              state_d   = ST_LAST;
              htrans_d  = HTRANS_IDLE;
              hbusreq_d = 1'b0;
            end else begin
              remain_d = remain_q - 4'd1;
              haddr_d  = haddr_q + (ADDR_W'(1) << hsize_q);
              if (hgrant) begin
                launch     = 1'b1;
                launch_seq = 1'b1;
              end else begin
                state_d  = ST_REQ;
                htrans_d = HTRANS_IDLE;
              end
            end
          end else if (hgrant) begin
            // Parked on IDLE (first beat) or BUSY (mid-burst) waiting for data.
            launch     = 1'b1;
            launch_seq = (htrans_q == HTRANS_BUSY);
          end else begin
            state_d  = ST_REQ;
            htrans_d = HTRANS_IDLE;
          end
        end
      end
      ST_LAST: begin
        if (err_seen) begin
          state_d  = ST_ERR;
          htrans_d = HTRANS_IDLE;
        end else if (dph_q && hready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (hready) begin
          done_d     = 1'b1;
          done_err_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write beat goes out only once its data is in hand; the data is taken
    // at launch and moves to hwdata when the address phase completes.
    if (launch) begin
      if (!hwrite_q || wdata_valid) begin
        htrans_d      = launch_seq ? HTRANS_SEQ : HTRANS_NONSEQ;
        wdata_ready_c = hwrite_q;
        if (hwrite_q) wbuf_d = wdata;
      end else begin
        htrans_d = launch_seq ? HTRANS_BUSY : HTRANS_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of statement order.
  // NOTE: the staging and data registers are reset too, so hwdata/rdata come
  // out of reset at zero rather than holding stale bus data.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q       <= ST_IDLE;
      htrans_q      <= HTRANS_IDLE;
      haddr_q       <= '0;
      hwrite_q      <= 1'b0;
      hsize_q       <= '0;
      hburst_q      <= '0;
      hwdata_q      <= '0;
      wbuf_q        <= '0;
      hbusreq_q     <= 1'b0;
      remain_q      <= '0;
      dph_q         <= 1'b0;
      dph_last_q    <= 1'b0;
      rdata_valid_q <= 1'b0;
      rdata_q       <= '0;
      rdata_last_q  <= 1'b0;
      done_q        <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      htrans_q      <= htrans_d;
      haddr_q       <= haddr_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
      wbuf_q        <= wbuf_d;
      hbusreq_q     <= hbusreq_d;
      remain_q      <= remain_d;
      dph_q         <= dph_d;
      dph_last_q    <= dph_last_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_q       <= rdata_d;
      rdata_last_q  <= rdata_last_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign wdata_ready = wdata_ready_c;
  assign rdata_valid = rdata_valid_q;
  assign rdata       = rdata_q;
  assign rdata_last  = rdata_last_q;
  assign done        = done_q;
  assign done_err    = done_err_q;
  assign haddr       = haddr_q;
  assign htrans      = htrans_q;
  assign hwrite      = hwrite_q;
  assign hsize       = hsize_q;
  assign hburst      = hburst_q;
  assign hwdata      = hwdata_q;
  assign hbusreq     = hbusreq_q;
  assign hlock       = 1'b0;

  // Single-master test bus: the current-master ID carries no information here.
  logic unused_hmaster;
  assign unused_hmaster = ^hmaster;

endmodule

// File: tb/tb_ahb_mst_driver.sv
// ----------------------------------------------------------------------------
// tb_ahb_mst_driver
// Directed bench for ahb_mst_driver: registered arbiter (hgrant follows
// hbusreq by one cycle), a small read slave returning mem[addr[6:3]], and a
// linear sequence of bursts with hand-computed cycle-by-cycle expectations.
// Cycle numbering: cycle 0 is the cycle in which the command is accepted.
// ----------------------------------------------------------------------------
module tb_ahb_mst_driver;
  import ahb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  logic              hclk = 1'b0;
  logic              hreset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_write;
  logic [2:0]        cmd_size;
  logic [3:0]        cmd_len;
  logic              wdata_valid;
  logic [DATA_W-1:0] wdata;
  logic              wdata_ready;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              done;
  logic              done_err;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hbusreq;
  logic              hlock;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic [1:0]        hresp;
  logic              hgrant = 1'b0;
  logic [3:0]        hmaster;

  ahb_mst_driver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .rdata_last(rdata_last),
    .done(done), .done_err(done_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hbusreq(hbusreq), .hlock(hlock),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .hgrant(hgrant),
    .hmaster(hmaster)
  );

  always #5 hclk = ~hclk;

  // Registered arbiter: grant one cycle after request.
  always @(posedge hclk) hgrant <= hbusreq;

  // Read slave: remember the accepted address, return mem[] in its data phase.
  logic [ADDR_W-1:0] s_addr = '0;
  logic [DATA_W-1:0] mem [16];
  always @(posedge hclk) if (hready && htrans[1]) s_addr <= haddr;
  assign hrdata = mem[s_addr[6:3]];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Presents a command in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [3:0] len);
    assert (({22'h0, addr[9:0]} + ((32'(len) + 32'd1) << size)) <= 32'd1024)
    else begin
      bad++;
      $error("FAIL cmd_1kb: command at %0h crosses a 1 KB boundary", addr);
    end
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_size  = size;
    cmd_len   = len;
    cmd_valid = 1'b1;
    #1;
    check("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int wbeat, stall, abeat, busy_cnt, rdy_cnt, pend, exp_rd, nrd;
    logic done_seen;

    for (int i = 0; i < 16; i++) mem[i] = 64'(i + 1);
    hreset      = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_write   = 1'b0;
    cmd_size    = '0;
    cmd_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;
    hready      = 1'b1;
    hresp       = HRESP_OKAY;
    hmaster     = '0;

    // ---------------- reset values ----------------
    tick();
    tick();
    check("rst_htrans", htrans, HTRANS_IDLE);
    check("rst_haddr", haddr, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hsize", hsize, 0);
    check("rst_hburst", hburst, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_hbusreq", hbusreq, 0);
    check("rst_hlock", hlock, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_last", rdata_last, 0);
    check("rst_done", done, 0);
    check("rst_done_err", done_err, 0);
    check("rst_wdata_ready", wdata_ready, 0);
    hreset = 1'b0;
    tick();

    // ---------------- read INCR4 @0x100, size 3, zero wait ----------------
    issue(32'h100, 1'b0, 3'd3, 4'd3);
    check("t1_busreq_c1", hbusreq, 1);
    check("t1_cmd_ready_c1", cmd_ready, 0);
    check("t1_htrans_c1", htrans, HTRANS_IDLE);
    tick();
    check("t1_htrans_c2", htrans, HTRANS_IDLE);
    for (int k = 3; k <= 9; k++) begin
      tick();
      if (k <= 6) begin
        check("t1_haddr", haddr, 64'(32'h100 + 32'(8 * (k - 3))));
        check("t1_htrans", htrans, (k == 3) ? HTRANS_NONSEQ : HTRANS_SEQ);
      end
      if (k == 3) begin
        check("t1_hburst", hburst, HBURST_INCR4);
        check("t1_hsize", hsize, 3);
      end
      if (k >= 5 && k <= 8) begin
        check("t1_rvalid", rdata_valid, 1);
        check("t1_rdata", rdata, 64'(k - 4));
        check("t1_rlast", rdata_last, (k == 8) ? 1 : 0);
      end
      if (k == 7) check("t1_busreq_drop", hbusreq, 0);
      check("t1_done", done, (k == 8) ? 1 : 0);
      if (k == 8) check("t1_done_err", done_err, 0);
      if (k == 9) check("t1_rvalid_after", rdata_valid, 0);
    end

    // ---------------- write SINGLE @0x40 ----------------
    wdata_valid = 1'b1;
    wdata       = 64'hA5A5;
    issue(32'h40, 1'b1, 3'd3, 4'd0);
    tick();                                   // cycle 2: beat launched
    check("t2_wready_c2", wdata_ready, 1);
    tick();                                   // cycle 3: NONSEQ
    wdata_valid = 1'b0;
    #1;
    check("t2_htrans", htrans, HTRANS_NONSEQ);
    check("t2_haddr", haddr, 32'h40);
    check("t2_hburst", hburst, HBURST_SINGLE);
    check("t2_hwrite", hwrite, 1);
    check("t2_wready_c3", wdata_ready, 0);
    tick();                                   // cycle 4: data phase
    check("t2_hwdata", hwdata, 64'hA5A5);
    check("t2_htrans_last", htrans, HTRANS_IDLE);
    check("t2_done_c4", done, 0);
    tick();                                   // cycle 5
    check("t2_done_c5", done, 1);
    check("t2_done_err", done_err, 0);
    check("t2_no_rvalid", rdata_valid, 0);

    // ---------------- write INCR8 @0x200 size 2, source stalls at beat 3 ----------------
    wbeat = 0; stall = 0; abeat = 0; busy_cnt = 0; rdy_cnt = 0; pend = -1;
    done_seen = 1'b0;
    wdata_valid = 1'b1;
    wdata       = 64'hD0;
    issue(32'h200, 1'b1, 3'd2, 4'd7);
    for (int c = 1; c < 40; c++) begin
      if (pend >= 0) check("t3_hwdata", hwdata, 64'(64'hD0 + 64'(pend)));
      pend = -1;
      if (done) begin
        done_seen = 1'b1;
        check("t3_done_err", done_err, 0);
        break;
      end
      if (htrans == HTRANS_BUSY) begin
        busy_cnt++;
        check("t3_busy_haddr", haddr, 32'h20C);
      end
      if (htrans[1]) begin
        check("t3_haddr", haddr, 64'(32'h200 + 32'(4 * abeat)));
        check("t3_htrans", htrans, (abeat == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
        pend = abeat;
        abeat++;
      end
      wdata_valid = (wbeat < 8) && !(wbeat == 3 && stall < 2);
      if (wbeat == 3 && stall < 2) stall++;
      wdata = 64'(64'hD0 + 64'(wbeat));
      #1;
      if (wdata_ready) rdy_cnt++;
      if (wdata_ready && wdata_valid) wbeat++;
      tick();
    end
    wdata_valid = 1'b0;
    check("t3_done_seen", done_seen, 1);
    check("t3_wready_cnt", rdy_cnt, 8);
    check("t3_busy_cnt", busy_cnt, 2);
    check("t3_beats", abeat, 8);

    // ---------------- read INCR4 @0x100, hready low 3 cycles on beat 2 ----------------
    exp_rd = 1;
    issue(32'h100, 1'b0, 3'd3, 4'd3);
    tick();                                   // cycle 2
    for (int k = 3; k <= 12; k++) begin
      tick();
      hready = !(k >= 5 && k <= 7);
      if (k >= 5 && k <= 8) begin
        check("t4_haddr_hold", haddr, 32'h110);
        check("t4_htrans_hold", htrans, HTRANS_SEQ);
      end
      if (k >= 6 && k <= 8) check("t4_rvalid_stall", rdata_valid, 0);
      if (rdata_valid) begin
        check("t4_rdata", rdata, 64'(exp_rd));
        check("t4_rlast", rdata_last, (exp_rd == 4) ? 1 : 0);
        exp_rd++;
      end
      check("t4_done", done, (k == 11) ? 1 : 0);
    end
    hready = 1'b1;
    check("t4_rd_count", exp_rd, 5);

    // ---------------- read INCR8 @0x100, ERROR on beat 2 ----------------
    nrd = 0;
    issue(32'h100, 1'b0, 3'd3, 4'd7);
    tick();                                   // cycle 2
    for (int k = 3; k <= 12; k++) begin
      tick();
      hready = (k != 6);
      hresp  = (k == 6 || k == 7) ? HRESP_ERROR : HRESP_OKAY;
      if (k == 6) check("t5_haddr_c6", haddr, 32'h118);
      if (k >= 7) check("t5_htrans_idle", htrans, HTRANS_IDLE);
      if (k == 7) check("t5_busreq_drop", hbusreq, 0);
      if (rdata_valid) nrd++;
      check("t5_done", done, (k == 8) ? 1 : 0);
      if (k == 8) check("t5_done_err", done_err, 1);
    end
    hresp = HRESP_OKAY;
    hready = 1'b1;
    check("t5_rd_count", nrd, 2);

    // ---------------- reset mid-INCR16, then a fresh command ----------------
    issue(32'h100, 1'b0, 3'd3, 4'd15);
    for (int k = 2; k <= 6; k++) tick();
    check("t6_midburst", htrans, HTRANS_SEQ);
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    check("t6_htrans", htrans, HTRANS_IDLE);
    check("t6_haddr", haddr, 0);
    check("t6_hsize", hsize, 0);
    check("t6_hburst", hburst, 0);
    check("t6_hbusreq", hbusreq, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_rdata_valid", rdata_valid, 0);
    check("t6_rdata", rdata, 0);
    check("t6_done", done, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_no_done", done, 0);
    end
    done_seen = 1'b0;
    nrd = 0;
    issue(32'h108, 1'b0, 3'd3, 4'd0);
    for (int c = 1; c < 20; c++) begin
      if (rdata_valid) begin
        nrd++;
        check("t6_rdata_new", rdata, 2);
        check("t6_rlast_new", rdata_last, 1);
      end
      if (done) begin
        done_seen = 1'b1;
        check("t6_done_err_new", done_err, 0);
        break;
      end
      tick();
    end
    check("t6_done_seen", done_seen, 1);
    check("t6_rd_count", nrd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
